uart_tx_arbiter: RTL

//  Shares one UART transmitter among N_REQ byte producers. Round-robin grant with packet lock:

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart transmitter with a stall watchdog
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int D_BITS  = 8,
  parameter int TO_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*D_BITS-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ack,
  output logic [N_REQ-1:0]          grant,
  output logic [D_BITS-1:0]         tx_din,
  output logic                      tx_start,
  input  logic                      tx_done_tick,
  input  logic [TO_BITS-1:0]        timeout_limit,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, WAIT_DONE, HOLD} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, win, idx, cap_idx;
  logic [N_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [D_BITS-1:0] din_q, din_d;
  logic [TO_BITS-1:0] timer_q, timer_d;
  logic start_q, start_d, err_q, err_d, busy_q, busy_d, last_q, last_d, cap, to_hit;
  // scan downward so the index closest after ptr is the last one written
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_q) + 1 + i) % N_REQ);
      win = req_valid[idx] ? idx : win;
    end
  end
  assign to_hit = (timeout_limit != '0) && (timer_q == timeout_limit - TO_BITS'(1));
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    last_d  = last_q;
    din_d   = din_q;
    ack_d   = '0;
    start_d = 1'b0;
    err_d   = 1'b0;
    cap     = 1'b0;
    cap_idx = owner_q;
    timer_d = (state_q == IDLE) ? '0 : timer_q + TO_BITS'(~&timer_q);
    case (state_q)
      IDLE: begin
        cap     = |req_valid;
        cap_idx = win;
      end
      WAIT_DONE: begin
        if (tx_done_tick) begin
          if (last_q) begin
            ptr_d   = owner_q;
            grant_d = '0;
            state_d = IDLE;
          end else if (req_valid[owner_q]) begin
            cap = 1'b1;
          end else begin
            state_d = HOLD;
            timer_d = '0;
          end
        end else begin
          err_d = to_hit;
        end
      end
      HOLD: begin
        cap   = req_valid[owner_q];
        err_d = !req_valid[owner_q] && to_hit;
      end
      default: state_d = IDLE;
    endcase
    if (err_d) begin
      grant_d = '0;
      ptr_d   = owner_q;
      state_d = IDLE;
    end
    if (cap) begin
      owner_d = cap_idx;
      grant_d = N_REQ'(1) << cap_idx;
      ack_d   = N_REQ'(1) << cap_idx;
      din_d   = req_data[cap_idx*D_BITS +: D_BITS];
      last_d  = req_last[cap_idx];
      start_d = 1'b1;
      timer_d = '0;
      state_d = WAIT_DONE;
    end
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      last_q  <= 1'b0;
      din_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      timer_q <= timer_d;
    end
  end
  assign req_ack     = ack_q;
  assign grant       = grant_q;
  assign tx_din      = din_q;
  assign tx_start    = start_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
endmodule
